frame_stream_reader: RTL and testbench



---
 rtl/frame_stream_pkg.sv | 66 ++++++
 rtl/frame_stream_fifo.sv | 45 ++++
 rtl/frame_stream_reader.sv | 146 ++++++++++++++
 tb/tb_frame_stream_reader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_stream_pkg.sv
// Shared types, FIFO sizing and the per-pixel operation for frame_stream_reader.
// Optional BRIGHTNESS_MODE_EN enables the saturating brightness path in pixel_op.
package frame_stream_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_THRESH = 2'd1,
    MODE_INVERT = 2'd2,
    MODE_BRIGHT = 2'd3
  } mode_t;

  typedef enum logic [2:0] {IDLE, VSYNC, HSYNC, DATA, DRAIN} state_t;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  // Widest channel the pixel operation supports; callers zero-extend and truncate.
  localparam int CH_W = 16;

  typedef struct packed {
    logic [CH_W-1:0] b;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] r;
  } rgb_t;

`ifdef BRIGHTNESS_MODE_EN
  function automatic logic [CH_W-1:0] sat_add(input logic [CH_W-1:0] c,
                                               input logic signed [CH_W:0] offset,
                                               input logic [CH_W-1:0] max_val);
    logic signed [CH_W+1:0] s;
    s = signed'({2'b00, c}) + (CH_W+2)'(offset);
    if (s < 0) return '0;
    if (s > signed'({2'b00, max_val})) return max_val;
    return s[CH_W-1:0];
  endfunction
`endif

  function automatic rgb_t pixel_op(input mode_t mode,
                                    input logic [CH_W-1:0] r,
                                    input logic [CH_W-1:0] g,
                                    input logic [CH_W-1:0] b,
                                    input logic signed [CH_W:0] brightness,
                                    input logic [CH_W-1:0] max_val,
                                    input logic [CH_W+1:0] thresh3);
    rgb_t res;
    logic [CH_W+1:0] sum;
`ifndef BRIGHTNESS_MODE_EN
    logic unused_brightness;
    unused_brightness = ^brightness;
`endif
    res = '{b: b, g: g, r: r};
    sum = {2'b00, r} + {2'b00, g} + {2'b00, b};
    case (mode)
      MODE_THRESH: res = (sum >= thresh3) ? '{b: max_val, g: max_val, r: max_val} : '0;
      MODE_INVERT: res = '{b: max_val - b, g: max_val - g, r: max_val - r};
`ifdef BRIGHTNESS_MODE_EN
      MODE_BRIGHT: res = '{b: sat_add(b, brightness, max_val),
                           g: sat_add(g, brightness, max_val),
                           r: sat_add(r, brightness, max_val)};
`endif
      default: ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/frame_stream_fifo.sv
// Four-entry synchronous FIFO for processed beats plus their line/frame tags.
module frame_stream_fifo
  import frame_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [FIFO_CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;

  assign push = wr_en && (count != FIFO_CNT_W'(FIFO_DEPTH));
  assign pop  = rd_en && (count != '0);

  // NOTE: storage is deliberately not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/frame_stream_reader.sv
// Streams a stored RGB frame with sync timing, per-pixel ops and a credit-limited output FIFO.
// Define BRIGHTNESS_MODE_EN to make mode 3 a saturating brightness offset (otherwise pass).
module frame_stream_reader
  import frame_stream_pkg::*;
#(
  parameter int IMAGE_WIDTH    = 768,
  parameter int IMAGE_HEIGHT   = 512,
  parameter int DATA_WIDTH     = 8,
  parameter int PIXELS_PER_CLK = 2,
  parameter int START_DELAY    = 100,
  parameter int HSYNC_DELAY    = 160,
  parameter int THRESHOLD      = 90
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [1:0]                             mode,
  input  logic signed [DATA_WIDTH:0]             brightness,
  output logic                                   mem_rd_en,
  output logic [$clog2(IMAGE_WIDTH*IMAGE_HEIGHT/PIXELS_PER_CLK)-1:0] mem_addr,
  input  logic [3*PIXELS_PER_CLK*DATA_WIDTH-1:0] mem_rd_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [3*PIXELS_PER_CLK*DATA_WIDTH-1:0] out_data,
  output logic                                   out_sol,
  output logic                                   out_eol,
  output logic                                   out_eof,
  output logic                                   vertical_pulse,
  output logic                                   busy,
  output logic                                   done_flag
);

  localparam int PIX_W  = 3 * PIXELS_PER_CLK * DATA_WIDTH;
  localparam int ADDR_W = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT / PIXELS_PER_CLK);
  localparam int BEATS  = IMAGE_WIDTH / PIXELS_PER_CLK;
  localparam int XW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int YW     = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int CW     = $clog2(((START_DELAY > HSYNC_DELAY) ? START_DELAY : HSYNC_DELAY) + 1);
  localparam logic [CH_W-1:0] MAX_VAL = CH_W'((1 << DATA_WIDTH) - 1);
  localparam logic [CH_W+1:0] THRESH3 = (CH_W+2)'(3 * THRESHOLD);

  state_t                    state;
  mode_t                     mode_q;
  logic signed [DATA_WIDTH:0] bright_q;
  logic [XW-1:0]             beat_idx;
  logic [YW-1:0]             line_idx;
  logic [CW-1:0]             delay_cnt;
  logic [ADDR_W-1:0]         rd_addr;
  logic                      p1_valid, p1_sol, p1_eol, p1_eof;
  logic [FIFO_CNT_W-1:0]     fifo_count;
  logic [PIX_W+2:0]          head;
  logic [PIX_W-1:0]          proc;
  logic                      rd_fire, last_beat, last_line;

  // A read may issue only if the FIFO can absorb it alongside the beat already in flight.
  assign rd_fire   = (state == DATA) && ((int'(fifo_count) + int'(p1_valid)) < FIFO_DEPTH);
  assign last_beat = (beat_idx == XW'(BEATS - 1));
  assign last_line = (line_idx == YW'(IMAGE_HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mode_q    <= MODE_PASS;
      bright_q  <= '0;
      beat_idx  <= '0;
      line_idx  <= '0;
      delay_cnt <= '0;
      rd_addr   <= '0;
      p1_valid  <= 1'b0;
      p1_sol    <= 1'b0;
      p1_eol    <= 1'b0;
      p1_eof    <= 1'b0;
    end else begin
      p1_valid <= rd_fire;
      p1_sol   <= rd_fire && (beat_idx == '0);
      p1_eol   <= rd_fire && last_beat;
      p1_eof   <= rd_fire && last_beat && last_line;
      case (state)
        IDLE: if (start) begin
          state     <= VSYNC;
          delay_cnt <= '0;
          beat_idx  <= '0;
          line_idx  <= '0;
          rd_addr   <= '0;
          mode_q    <= mode_t'(mode);
          bright_q  <= brightness;
        end
        VSYNC: if (delay_cnt == CW'(START_DELAY - 1)) begin
          delay_cnt <= '0;
          state     <= HSYNC;
        end else delay_cnt <= delay_cnt + 1'b1;
        HSYNC: if (delay_cnt == CW'(HSYNC_DELAY - 1)) begin
          delay_cnt <= '0;
          state     <= DATA;
        end else delay_cnt <= delay_cnt + 1'b1;
        DATA: if (rd_fire) begin
          rd_addr <= rd_addr + 1'b1;
          if (last_beat) begin
            beat_idx <= '0;
            if (last_line) state <= DRAIN;
            else begin
              line_idx <= line_idx + 1'b1;
              state    <= HSYNC;
            end
          end else beat_idx <= beat_idx + 1'b1;
        end
        DRAIN: if (done_flag) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < PIXELS_PER_CLK; i++) begin : g_pix
    localparam int BASE = i * 3 * DATA_WIDTH;
    rgb_t px;
    logic unused_px;
    assign px = pixel_op(mode_q,
                         CH_W'(mem_rd_data[BASE +: DATA_WIDTH]),
                         CH_W'(mem_rd_data[BASE + DATA_WIDTH +: DATA_WIDTH]),
                         CH_W'(mem_rd_data[BASE + 2*DATA_WIDTH +: DATA_WIDTH]),
                         (CH_W+1)'(bright_q), MAX_VAL, THRESH3);
    assign proc[BASE +: 3*DATA_WIDTH] = {px.b[DATA_WIDTH-1:0], px.g[DATA_WIDTH-1:0],
                                         px.r[DATA_WIDTH-1:0]};
    assign unused_px = ^px;
  end

  frame_stream_fifo #(.WIDTH(PIX_W + 3)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (p1_valid),
    .wr_data ({p1_eof, p1_eol, p1_sol, proc}),
    .rd_en   (out_ready),
    .rd_data (head),
    .count   (fifo_count)
  );

  // Stale FIFO storage must never leak onto the outputs while nothing is queued.
  assign out_valid = (fifo_count != '0);
  assign {out_eof, out_eol, out_sol, out_data} = out_valid ? head : '0;
  assign done_flag      = out_valid && out_ready && out_eof;
  assign mem_rd_en      = rd_fire;
  assign mem_addr       = rd_addr;
  assign vertical_pulse = (state == VSYNC);
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_frame_stream_reader.sv
// Directed bench for frame_stream_reader on a small 8x2 frame with a registered memory model.
module tb_frame_stream_reader;

  localparam int W = 8, H = 2, PPC = 2, DW = 8, SD = 4, HD = 3, TH = 30;
  localparam int NBEATS = W * H / PPC;
  localparam int PIX_W  = 3 * PPC * DW;
  localparam int AW     = $clog2(NBEATS);

  logic                 clk = 1'b0;
  logic                 reset, start, out_ready;
  logic [1:0]           mode;
  logic signed [DW:0]   brightness;
  logic                 mem_rd_en, out_valid, out_sol, out_eol, out_eof;
  logic                 vertical_pulse, busy, done_flag;
  logic [AW-1:0]        mem_addr;
  logic [PIX_W-1:0]     mem_rd_data, out_data;

  always #5 clk = ~clk;

  frame_stream_reader #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_WIDTH(DW), .PIXELS_PER_CLK(PPC),
    .START_DELAY(SD), .HSYNC_DELAY(HD), .THRESHOLD(TH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .brightness(brightness),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sol(out_sol), .out_eol(out_eol), .out_eof(out_eof),
    .vertical_pulse(vertical_pulse), .busy(busy), .done_flag(done_flag)
  );

  logic [PIX_W-1:0] mem [NBEATS];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  // Monitor: logs accepted beats and reads, and tracks protocol invariants.
  logic [PIX_W-1:0] bt_data [256];
  logic [2:0]       bt_tag  [256];
  logic             bt_done [256];
  int               rd_log  [256];
  int bt_n = 0, rd_n = 0, busy_n = 0, vp_n = 0, done_n = 0, outstanding = 0;
  int credit_bad = 0, stable_bad = 0, done_bad = 0;
  logic             prev_stall = 1'b0;
  logic [PIX_W+2:0] prev_head;

  always @(negedge clk) begin
    if (reset) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (busy) busy_n++;
      if (vertical_pulse) vp_n++;
      if (prev_stall && (!out_valid || {out_eof, out_eol, out_sol, out_data} !== prev_head))
        stable_bad++;
      if (done_flag) begin
        done_n++;
        if (!(out_valid && out_ready && out_eof)) done_bad++;
      end
      if (mem_rd_en) begin
        if (outstanding >= 4) credit_bad++;
        if (rd_n < 256) rd_log[rd_n] = int'(mem_addr);
        rd_n++;
        outstanding++;
      end
      if (out_valid && out_ready) begin
        if (bt_n < 256) begin
          bt_data[bt_n] = out_data;
          bt_tag[bt_n]  = {out_eof, out_eol, out_sol};
          bt_done[bt_n] = done_flag;
        end
        bt_n++;
        outstanding--;
      end
      prev_stall = out_valid && !out_ready;
      prev_head  = {out_eof, out_eol, out_sol, out_data};
    end
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int ref_ch(input int m, input int c, input int sum, input int br);
    int v;
    case (m)
      1: return (sum >= 3 * TH) ? 255 : 0;
      2: return 255 - c;
`ifdef BRIGHTNESS_MODE_EN
      3: begin
        v = c + br;
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
      end
`endif
      default: return c;
    endcase
  endfunction

  function automatic logic [PIX_W-1:0] ref_beat(input int m, input int br,
                                                input logic [PIX_W-1:0] w);
    logic [PIX_W-1:0] res;
    int r, g, b, s;
    res = '0;
    for (int p = 0; p < PPC; p++) begin
      r = int'(w[p*24 +: 8]);
      g = int'(w[p*24+8 +: 8]);
      b = int'(w[p*24+16 +: 8]);
      s = r + g + b;
      res[p*24 +: 24] = {8'(ref_ch(m, b, s, br)), 8'(ref_ch(m, g, s, br)),
                         8'(ref_ch(m, r, s, br))};
    end
    return res;
  endfunction

  task automatic run_frame(input int m, input int br, input int ready_period, input bit disturb);
    int done_base, cyc;
    mode       = 2'(m);
    brightness = (DW+1)'(br);
    start      = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    done_base = done_n;
    cyc       = 0;
    while (done_n == done_base && cyc < 2000) begin
      out_ready = ((cyc % ready_period) == 0);
      if (disturb && cyc == 8) begin
        start      = 1'b1;
        mode       = 2'd2;
        brightness = (DW+1)'(55);
      end
      if (disturb && cyc == 9) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check("frame_done", 64'(done_n - done_base), 64'd1);
    out_ready = 1'b1;
  endtask

  task automatic check_frame(input string tag, input int m, input int br,
                             input int rd_base, input int bt_base);
    int idx;
    check({tag, "_beats"}, 64'(bt_n - bt_base), 64'(NBEATS));
    check({tag, "_reads"}, 64'(rd_n - rd_base), 64'(NBEATS));
    for (int i = 0; i < NBEATS; i++) begin
      idx = bt_base + i;
      check($sformatf("%s_addr%0d", tag, i), 64'(rd_log[rd_base + i]), 64'(i));
      check($sformatf("%s_data%0d", tag, i), 64'(bt_data[idx]), 64'(ref_beat(m, br, mem[i])));
      check($sformatf("%s_tags%0d", tag, i), 64'(bt_tag[idx]),
            64'({i == NBEATS - 1, (i % 4) == 3, (i % 4) == 0}));
      check($sformatf("%s_done%0d", tag, i), 64'(bt_done[idx]), 64'(i == NBEATS - 1));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    check({tag, "_addr"},  64'(mem_addr), 64'd0);
    check({tag, "_vsync"}, 64'(vertical_pulse), 64'd0);
    check({tag, "_done"},  64'(done_flag), 64'd0);
    check({tag, "_data"},  64'({out_eof, out_eol, out_sol, out_data}), 64'd0);
  endtask

  initial begin
    int rb, bb, busy_b, vp_b, done_b;
    reset      = 1'b1;
    start      = 1'b0;
    mode       = 2'd0;
    brightness = '0;
    out_ready  = 1'b1;
    for (int k = 0; k < NBEATS; k++)
      for (int p = 0; p < PPC; p++)
        mem[k][p*24 +: 24] = {8'(250 - 8*k - p), 8'(8*k + p + 64), 8'(8*k + p + 1)};
    mem[0] = 48'h1D1E1E_1E1E1E;   // (30,30,29) and (30,30,30)
    mem[1] = 48'h141414_C8C8C8;   // (20,20,20) and (200,200,200)

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Pass-through frame with frame timing.
    rb = rd_n; bb = bt_n; busy_b = busy_n; vp_b = vp_n;
    run_frame(0, 0, 1, 1'b0);
    check_frame("pass", 0, 0, rb, bb);
    check("pass_busy_cycles", 64'(busy_n - busy_b), 64'(SD + H * (HD + W / PPC) + 2));
    check("pass_vsync_cycles", 64'(vp_n - vp_b), 64'(SD));

    // Threshold boundary: sum 90 passes, sum 89 does not.
    rb = rd_n; bb = bt_n;
    run_frame(1, 0, 1, 1'b0);
    check_frame("thresh", 1, 0, rb, bb);
    check("thresh_boundary", 64'(bt_data[bb]), 64'h000000_FFFFFF);

    // Brightness saturation in both directions.
    rb = rd_n; bb = bt_n;
    run_frame(3, 100, 1, 1'b0);
    check_frame("bright_pos", 3, 100, rb, bb);
`ifdef BRIGHTNESS_MODE_EN
    check("bright_pos_sat", 64'(bt_data[bb + 1]), 64'h787878_FFFFFF);
`else
    check("bright_pos_sat", 64'(bt_data[bb + 1]), 64'h141414_C8C8C8);
`endif
    rb = rd_n; bb = bt_n;
    run_frame(3, -50, 1, 1'b0);
    check_frame("bright_neg", 3, -50, rb, bb);
`ifdef BRIGHTNESS_MODE_EN
    check("bright_neg_sat", 64'(bt_data[bb + 1]), 64'h000000_969696);
`else
    check("bright_neg_sat", 64'(bt_data[bb + 1]), 64'h141414_C8C8C8);
`endif

    // Invert with out_ready high one cycle in three.
    rb = rd_n; bb = bt_n;
    run_frame(2, 0, 3, 1'b0);
    check_frame("invert_stall", 2, 0, rb, bb);

    // Start and mode change mid-frame are ignored.
    rb = rd_n; bb = bt_n;
    run_frame(0, 0, 1, 1'b1);
    check_frame("ignore_start", 0, 0, rb, bb);
    repeat (5) @(posedge clk);
    #1;
    check("no_second_frame", 64'(busy), 64'd0);

    // Reset in the middle of a line, then a clean frame.
    mode  = 2'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    done_b = done_n;
    reset  = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("midreset");
    reset = 1'b0;
    @(posedge clk); #1;
    check("midreset_no_done", 64'(done_n - done_b), 64'd0);
    rb = rd_n; bb = bt_n;
    run_frame(0, 0, 1, 1'b0);
    check_frame("after_reset", 0, 0, rb, bb);

    check("credit_rule", 64'(credit_bad), 64'd0);
    check("stall_stable", 64'(stable_bad), 64'd0);
    check("done_alignment", 64'(done_bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
